// File: rtl/rv_imm_target_pipe_pkg.sv
// Shared definitions for the immediate/target pipeline and its decoder.
//   OPCODE_*     : RV32 major opcodes (ir[6:0]) recognised by the decoder
//   fmt_t        : 3-bit instruction format code reported alongside the immediate
//   xlen_legal   : datapath widths the pipeline supports
//   stages_legal : pipeline depths the pipeline supports
package rv_imm_target_pipe_pkg;

    localparam logic [6:0] OPCODE_LOAD     = 7'b0000011;
    localparam logic [6:0] OPCODE_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPCODE_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPCODE_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPCODE_STORE    = 7'b0100011;
    localparam logic [6:0] OPCODE_OP       = 7'b0110011;
    localparam logic [6:0] OPCODE_LUI      = 7'b0110111;
    localparam logic [6:0] OPCODE_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPCODE_JALR     = 7'b1100111;
    localparam logic [6:0] OPCODE_JAL      = 7'b1101111;
    localparam logic [6:0] OPCODE_SYSTEM   = 7'b1110011;

    typedef enum logic [2:0] {
        FMT_R = 3'd0,
        FMT_I = 3'd1,
        FMT_S = 3'd2,
        FMT_B = 3'd3,
        FMT_U = 3'd4,
        FMT_J = 3'd5
    } fmt_t;

    localparam int unsigned XLEN_32 = 32;
    localparam int unsigned XLEN_64 = 64;

    function automatic logic xlen_legal(input int unsigned xlen);
        return (xlen == XLEN_32) || (xlen == XLEN_64);
    endfunction

    function automatic logic stages_legal(input int unsigned stages);
        return (stages == 1) || (stages == 2);
    endfunction

endpackage

// File: rtl/rv_imm_target_pipe_if.sv
// Handshake bundle between fetch (master) and the immediate/target pipeline (slave).
//   flush                    : master -> slave, drop everything in flight
//   in_valid/in_ir/in_pc     : master -> slave, offered instruction and its PC
//   in_ready                 : slave  -> master, pipeline can accept this cycle
//   out_valid/out_imm/...    : slave  -> master, decoded result
//   out_ready                : master -> slave, result consumed
interface rv_imm_target_pipe_if #(
    parameter int unsigned XLEN = 32
);
    import rv_imm_target_pipe_pkg::*;

    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_ir;
    logic [XLEN-1:0] in_pc;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_imm;
    logic [XLEN-1:0] out_target;
    fmt_t            out_fmt;
    logic            out_illegal;

    modport master (
        output flush, in_valid, in_ir, in_pc, out_ready,
        input  in_ready, out_valid, out_imm, out_target, out_fmt, out_illegal
    );

    modport slave (
        input  flush, in_valid, in_ir, in_pc, out_ready,
        output in_ready, out_valid, out_imm, out_target, out_fmt, out_illegal
    );

endinterface

// File: rtl/rv_imm_decode.sv
// Purely combinational RV32 immediate decoder.
//   ir      in  32    raw instruction word
//   imm     out XLEN  sign-extended immediate (0 for R-format)
//   fmt     out 3     instruction format
//   illegal out 1     opcode not recognised (includes ir[1:0] != 2'b11)
module rv_imm_decode
    import rv_imm_target_pipe_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [31:0]     ir,
    output logic [XLEN-1:0] imm,
    output fmt_t            fmt,
    output logic            illegal
);

    logic signed [31:0] i_imm;
    logic signed [31:0] s_imm;
    logic signed [31:0] b_imm;
    logic signed [31:0] u_imm;
    logic signed [31:0] j_imm;
    logic signed [31:0] imm32;

    assign i_imm = {{20{ir[31]}}, ir[31:20]};
    assign s_imm = {{20{ir[31]}}, ir[31:25], ir[11:7]};
    assign b_imm = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
    assign u_imm = {ir[31:12], 12'b0};
    assign j_imm = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};

    // Every recognised opcode ends in 2'b11, so a bad ir[1:0] lands in default.
    always_comb begin
        fmt     = FMT_I;
        imm32   = i_imm;
        illegal = 1'b0;
        case (ir[6:0])
            OPCODE_OP_IMM, OPCODE_LOAD, OPCODE_JALR,
            OPCODE_SYSTEM, OPCODE_MISC_MEM: begin
                fmt   = FMT_I;
                imm32 = i_imm;
            end
            OPCODE_STORE: begin
                fmt   = FMT_S;
                imm32 = s_imm;
            end
            OPCODE_BRANCH: begin
                fmt   = FMT_B;
                imm32 = b_imm;
            end
            OPCODE_LUI, OPCODE_AUIPC: begin
                fmt   = FMT_U;
                imm32 = u_imm;
            end
            OPCODE_JAL: begin
                fmt   = FMT_J;
                imm32 = j_imm;
            end
            OPCODE_OP: begin
                fmt   = FMT_R;
                imm32 = '0;
            end
            default: begin
                fmt     = FMT_I;
                imm32   = i_imm;
                illegal = 1'b1;
            end
        endcase
    end

    // Signed size cast sign-extends bit 31 up to XLEN.
    assign imm = XLEN'(imm32);

endmodule

// File: rtl/rv_imm_target_pipe.sv
// Pipelined immediate generator + PC-relative target adder.
//   clk    in  1   rising-edge clock
//   rst_n  in  1   asynchronous active-low reset
//   bus    slave modport of rv_imm_target_pipe_if:
//          in_valid/in_ready/in_ir/in_pc  accepted instruction
//          out_valid/out_ready/out_imm/out_target/out_fmt/out_illegal  result
//          flush  drops in-flight entries and the one offered this cycle
// STAGES=1: decode and add feed the output register directly.
// STAGES=2: decode results and pc are registered first; the adder feeds the output register.
module rv_imm_target_pipe
    import rv_imm_target_pipe_pkg::*;
#(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned STAGES = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    rv_imm_target_pipe_if.slave bus
);

    if (!xlen_legal(XLEN)) begin : g_bad_xlen
        $error("rv_imm_target_pipe: XLEN must be 32 or 64");
    end
    if (!stages_legal(STAGES)) begin : g_bad_stages
        $error("rv_imm_target_pipe: STAGES must be 1 or 2");
    end

    logic [XLEN-1:0] dec_imm;
    fmt_t            dec_fmt;
    logic            dec_illegal;

    rv_imm_decode #(
        .XLEN (XLEN)
    ) u_decode (
        .ir      (bus.in_ir),
        .imm     (dec_imm),
        .fmt     (dec_fmt),
        .illegal (dec_illegal)
    );

    // Feed into the output register, whichever stage provides it.
    logic            src_valid;
    logic [XLEN-1:0] src_imm;
    logic [XLEN-1:0] src_pc;
    fmt_t            src_fmt;
    logic            src_illegal;
    logic            src_load;

    logic            ready;

    logic            out_valid_q;
    logic [XLEN-1:0] out_imm_q;
    logic [XLEN-1:0] out_target_q;
    fmt_t            out_fmt_q;
    logic            out_illegal_q;

    logic            out_free;

    assign out_free = !out_valid_q || bus.out_ready;
    assign src_load = src_valid && out_free;

    if (STAGES == 2) begin : g_two
        logic            accept;
        logic            s1_valid;
        logic [XLEN-1:0] s1_imm;
        logic [XLEN-1:0] s1_pc;
        fmt_t            s1_fmt;
        logic            s1_illegal;

        assign accept = bus.in_valid && ready;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                s1_valid   <= 1'b0;
                s1_imm     <= '0;
                s1_pc      <= '0;
                s1_fmt     <= FMT_R;
                s1_illegal <= 1'b0;
            end else begin
                if (bus.flush) begin
                    s1_valid <= 1'b0;
                end else if (accept) begin
                    s1_valid <= 1'b1;
                end else if (src_load) begin
                    s1_valid <= 1'b0;
                end
                if (accept) begin
                    s1_imm     <= dec_imm;
                    s1_pc      <= bus.in_pc;
                    s1_fmt     <= dec_fmt;
                    s1_illegal <= dec_illegal;
                end
            end
        end

        assign src_valid   = s1_valid;
        assign src_imm     = s1_imm;
        assign src_pc      = s1_pc;
        assign src_fmt     = s1_fmt;
        assign src_illegal = s1_illegal;
        assign ready       = !s1_valid || src_load;
    end else begin : g_one
        assign src_valid   = bus.in_valid;
        assign src_imm     = dec_imm;
        assign src_pc      = bus.in_pc;
        assign src_fmt     = dec_fmt;
        assign src_illegal = dec_illegal;
        assign ready       = out_free;
    end

    // Data only moves on a load, so outputs hold while stalled; flush clears
    // valid only and may leave stale data behind.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q   <= 1'b0;
            out_imm_q     <= '0;
            out_target_q  <= '0;
            out_fmt_q     <= FMT_R;
            out_illegal_q <= 1'b0;
        end else begin
            if (bus.flush) begin
                out_valid_q <= 1'b0;
            end else if (src_load) begin
                out_valid_q <= 1'b1;
            end else if (bus.out_ready) begin
                out_valid_q <= 1'b0;
            end
            if (src_load) begin
                out_imm_q     <= src_imm;
                out_target_q  <= src_pc + src_imm;
                out_fmt_q     <= src_fmt;
                out_illegal_q <= src_illegal;
            end
        end
    end

    assign bus.in_ready    = ready;
    assign bus.out_valid   = out_valid_q;
    assign bus.out_imm     = out_imm_q;
    assign bus.out_target  = out_target_q;
    assign bus.out_fmt     = out_fmt_q;
    assign bus.out_illegal = out_illegal_q;

endmodule

// File: tb/tb_rv_imm_target_pipe.sv
// Directed bench: XLEN=32/STAGES=2 and XLEN=64/STAGES=1 instances on one clock.
module tb_rv_imm_target_pipe;
    import rv_imm_target_pipe_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    rv_imm_target_pipe_if #(.XLEN(32)) b32 ();
    rv_imm_target_pipe_if #(.XLEN(64)) b64 ();

    rv_imm_target_pipe #(.XLEN(32), .STAGES(2)) dut32 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b32)
    );

    rv_imm_target_pipe #(.XLEN(64), .STAGES(1)) dut64 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b64)
    );

    int unsigned nvec = 0;
    int unsigned nmis = 0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nmis++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send32(input logic [31:0] ir, input logic [31:0] pc);
        b32.in_valid = 1'b1;
        b32.in_ir    = ir;
        b32.in_pc    = pc;
        step();
        b32.in_valid = 1'b0;
        step();
    endtask

    task automatic send64(input logic [31:0] ir, input logic [63:0] pc);
        b64.in_valid = 1'b1;
        b64.in_ir    = ir;
        b64.in_pc    = pc;
        step();
        b64.in_valid = 1'b0;
    endtask

    task automatic exp32(input string tag, input logic [31:0] imm, input logic [31:0] tgt,
                         input logic [2:0] fmt, input logic ill);
        chk({tag, "_valid"},   64'(b32.out_valid),   64'd1);
        chk({tag, "_imm"},     64'(b32.out_imm),     64'(imm));
        chk({tag, "_target"},  64'(b32.out_target),  64'(tgt));
        chk({tag, "_fmt"},     64'(b32.out_fmt),     64'(fmt));
        chk({tag, "_illegal"}, 64'(b32.out_illegal), 64'(ill));
    endtask

    task automatic exp64(input string tag, input logic [63:0] imm, input logic [63:0] tgt,
                         input logic [2:0] fmt, input logic ill);
        chk({tag, "_valid"},   64'(b64.out_valid),   64'd1);
        chk({tag, "_imm"},     b64.out_imm,          imm);
        chk({tag, "_target"},  b64.out_target,       tgt);
        chk({tag, "_fmt"},     64'(b64.out_fmt),     64'(fmt));
        chk({tag, "_illegal"}, 64'(b64.out_illegal), 64'(ill));
    endtask

    task automatic exp_reset32(input string tag);
        chk({tag, "_valid"},   64'(b32.out_valid),   64'd0);
        chk({tag, "_ready"},   64'(b32.in_ready),    64'd1);
        chk({tag, "_imm"},     64'(b32.out_imm),     64'd0);
        chk({tag, "_target"},  64'(b32.out_target),  64'd0);
        chk({tag, "_fmt"},     64'(b32.out_fmt),     64'd0);
        chk({tag, "_illegal"}, 64'(b32.out_illegal), 64'd0);
    endtask

    initial begin
        logic signed [31:0] v;
        logic [31:0]        pc;

        rst_n = 1'b0;
        b32.flush = 1'b0; b32.in_valid = 1'b0; b32.in_ir = '0; b32.in_pc = '0; b32.out_ready = 1'b1;
        b64.flush = 1'b0; b64.in_valid = 1'b0; b64.in_ir = '0; b64.in_pc = '0; b64.out_ready = 1'b1;
        step();
        step();
        exp_reset32("rst32");
        chk("rst64_valid", 64'(b64.out_valid), 64'd0);
        chk("rst64_ready", 64'(b64.in_ready),  64'd1);
        chk("rst64_imm",   b64.out_imm,        64'd0);
        #2 rst_n = 1'b1;
        step();

        // BEQ, two-stage latency
        b32.in_valid = 1'b1; b32.in_ir = 32'hFE000EE3; b32.in_pc = 32'h100;
        step();
        b32.in_valid = 1'b0;
        chk("beq_early_valid", 64'(b32.out_valid), 64'd0);
        step();
        exp32("beq", 32'hFFFFFFFC, 32'h000000FC, 3'd3, 1'b0);

        // XLEN=64, one stage
        send64(32'h800002B7, 64'h0);
        exp64("lui64", 64'hFFFFFFFF_80000000, 64'hFFFFFFFF_80000000, 3'd4, 1'b0);
        send64(32'h0080006F, 64'h1000);
        exp64("jal64", 64'h8, 64'h1008, 3'd5, 1'b0);
        send64(32'hFE512C23, 64'h2000);
        exp64("sw64", 64'hFFFFFFFF_FFFFFFF8, 64'h1FF8, 3'd2, 1'b0);
        send64(32'h00800013, 64'hFFFFFFFF_FFFFFFFC);
        exp64("wrap64", 64'h8, 64'h4, 3'd1, 1'b0);

        // Assorted formats and illegal cases, XLEN=32
        send32(32'h00000000, 32'hFFFFFFFC);
        exp32("zero_ir", 32'h0, 32'hFFFFFFFC, 3'd1, 1'b1);
        send32(32'h00800013, 32'hFFFFFFFC);
        exp32("wrap32", 32'h8, 32'h4, 3'd1, 1'b0);
        send32(32'h00000001, 32'h0);
        exp32("low_bits", 32'h0, 32'h0, 3'd1, 1'b1);
        send32(32'h003100B3, 32'h40);
        exp32("add_r", 32'h0, 32'h40, 3'd0, 1'b0);
        send32(32'h12345097, 32'h10);
        exp32("auipc", 32'h12345000, 32'h12345010, 3'd4, 1'b0);
        send32(32'hFFC08067, 32'h200);
        exp32("jalr", 32'hFFFFFFFC, 32'h1FC, 3'd1, 1'b0);
        send32(32'h800002B7, 32'h0);
        exp32("lui32", 32'h80000000, 32'h80000000, 3'd4, 1'b0);
        step();

        // Back-to-back stream of 8
        for (int c = 0; c <= 8; c++) begin
            if (c < 8) begin
                v  = c * 100 - 300;
                pc = 32'h3000 + 32'(c * 4);
                b32.in_valid = 1'b1;
                b32.in_ir    = {v[11:0], 20'h00013};
                b32.in_pc    = pc;
            end else begin
                b32.in_valid = 1'b0;
            end
            chk("stream_ready", 64'(b32.in_ready), 64'd1);
            step();
            if (c >= 1) begin
                v  = (c - 1) * 100 - 300;
                pc = 32'h3000 + 32'((c - 1) * 4);
                exp32("stream", v, pc + v, 3'd1, 1'b0);
            end
        end
        step();
        chk("stream_drain_valid", 64'(b32.out_valid), 64'd0);

        // Stall with pipe full
        b32.out_ready = 1'b0;
        b32.in_valid = 1'b1; b32.in_ir = 32'h00100013; b32.in_pc = 32'h10;
        chk("stall_ready0", 64'(b32.in_ready), 64'd1);
        step();
        b32.in_ir = 32'h00200013; b32.in_pc = 32'h20;
        chk("stall_ready1", 64'(b32.in_ready), 64'd1);
        step();
        b32.in_ir = 32'h00300013; b32.in_pc = 32'h30;
        chk("stall_full_ready", 64'(b32.in_ready), 64'd0);
        for (int k = 0; k < 5; k++) begin
            chk("stall_hold_ready", 64'(b32.in_ready), 64'd0);
            exp32("stall_hold", 32'h1, 32'h11, 3'd1, 1'b0);
            step();
        end
        b32.out_ready = 1'b1;
        #1;
        chk("release_ready", 64'(b32.in_ready), 64'd1);
        step();
        b32.in_valid = 1'b0;
        exp32("release_b", 32'h2, 32'h22, 3'd1, 1'b0);
        step();
        exp32("release_c", 32'h3, 32'h33, 3'd1, 1'b0);
        step();
        chk("release_empty", 64'(b32.out_valid), 64'd0);

        // Flush with two in flight plus one being accepted
        b32.in_valid = 1'b1; b32.in_ir = 32'h00400013; b32.in_pc = 32'h40;
        step();
        b32.in_ir = 32'h00500013; b32.in_pc = 32'h50;
        step();
        b32.in_ir = 32'h00600013; b32.in_pc = 32'h60;
        b32.flush = 1'b1;
        #1;
        chk("flush_ready", 64'(b32.in_ready), 64'd1);
        chk("flush_pre_valid", 64'(b32.out_valid), 64'd1);
        step();
        b32.flush = 1'b0;
        b32.in_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk("flush_valid", 64'(b32.out_valid), 64'd0);
            step();
        end

        // Asynchronous reset mid-stream
        b32.in_valid = 1'b1; b32.in_ir = 32'h00700013; b32.in_pc = 32'h70;
        b64.in_valid = 1'b1; b64.in_ir = 32'h800002B7; b64.in_pc = 64'h0;
        step();
        step();
        exp32("pre_rst", 32'h7, 32'h77, 3'd1, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        exp_reset32("async_rst32");
        chk("async_rst64_valid", 64'(b64.out_valid), 64'd0);
        chk("async_rst64_imm",   b64.out_imm,        64'd0);
        chk("async_rst64_fmt",   64'(b64.out_fmt),   64'd0);
        b32.in_valid = 1'b0;
        b64.in_valid = 1'b0;
        #1 rst_n = 1'b1;
        step();
        send32(32'hFE000EE3, 32'h100);
        exp32("post_rst_beq", 32'hFFFFFFFC, 32'h000000FC, 3'd3, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
